// File: rtl/fetch_stage.sv
// IF stage with IF/ID pipeline register: owns the PC, fetches over an addr_ok/data_ok
// instruction bus with one request outstanding, and parks one word while ID is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic        valid_d
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FULL
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        discard_q, discard_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        inst_req_q, inst_req_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;

  logic        advance;
  logic        id_load;
  logic [31:0] load_instr;
  logic [31:0] load_pc;
  logic [31:0] redirect_target;

  assign advance         = !stall_d && !flush_d;
  assign redirect_target = redirect_pc & ~32'h3;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    discard_d   = discard_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    id_load     = 1'b0;
    load_instr  = inst_rdata;
    load_pc     = req_pc_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (inst_addr_ok) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_WAIT;
          // A redirect in the accept cycle makes the accepted request stale.
          if (redirect_valid) begin
            discard_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_d = S_REQ;
          if (discard_q || redirect_valid) begin
            discard_d = 1'b0;
          end else if (advance) begin
            id_load = 1'b1;
          end else begin
            buf_pc_d    = req_pc_q;
            buf_instr_d = inst_rdata;
            state_d     = S_FULL;
          end
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      S_FULL: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (advance) begin
          id_load    = 1'b1;
          load_instr = buf_instr_q;
          load_pc    = buf_pc_q;
          state_d    = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
    end
  end

  // IF/ID register: flush beats stall, an unstalled cycle without a load is a bubble.
  always_comb begin
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    if (flush_d) begin
      id_valid_d = 1'b0;
      id_instr_d = 32'h0;
    end else if (id_load) begin
      id_valid_d = 1'b1;
      id_instr_d = load_instr;
      id_pc_d    = load_pc;
    end else if (!stall_d) begin
      id_valid_d = 1'b0;
      id_instr_d = 32'h0;
    end
  end

  assign inst_req_d = (state_d == S_REQ);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= 32'h0;
      discard_q   <= 1'b0;
      buf_pc_q    <= 32'h0;
      buf_instr_q <= 32'h0;
      inst_req_q  <= 1'b0;
      id_instr_q  <= 32'h0;
      id_pc_q     <= 32'h0;
      id_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      discard_q   <= discard_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      inst_req_q  <= inst_req_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      id_valid_q  <= id_valid_d;
    end
  end

  assign inst_req  = inst_req_q;
  assign inst_addr = fetch_pc_q;
  assign instr_d   = id_instr_q;
  assign pc_d      = id_pc_q;
  assign valid_d   = id_valid_q;

endmodule
